// File: rtl/msx_mouse_host.sv
// Host-side MSX joystick-port mouse reader: strobes pin 8, gathers the four delta
// nibbles plus buttons, and republishes each read as a 25-bit ps2_mouse packet.
module msx_mouse_host #(
  parameter int SETTLE_CYC = 1024,
  parameter int POLL_CYC   = 43000,
  parameter int CNT_W      = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic [5:0]  pin_in,
  output logic        strobe,
  output logic [24:0] ps2_mouse,
  output logic        busy
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StXh   = 3'd1;
  localparam logic [2:0] StXl   = 3'd2;
  localparam logic [2:0] StYh   = 3'd3;
  localparam logic [2:0] StYl   = 3'd4;
  localparam logic [2:0] StPub  = 3'd5;

  localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PollLast   = CNT_W'(POLL_CYC - 1);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);

  logic [2:0]       st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [7:0]       xr_q, xr_d, yr_q, yr_d;
  logic             btn_l_q, btn_l_d, btn_r_q, btn_r_d;
  logic             strobe_q, strobe_d;
  logic [24:0]      pkt_q, pkt_d;

  logic [3:0] nib;
  logic       at_settle;
  logic [7:0] dx, dy;

  assign nib       = sync2_q[3:0];
  assign at_settle = (cnt_q == SettleLast);

  // MSX positive X is leftward, so negate; -0x80 does not fit and saturates.
  assign dx = (xr_q == 8'h80) ? 8'h7F : (~xr_q + 8'd1);
  assign dy = yr_q;

  always_comb begin
    sync1_d  = pin_in;
    sync2_d  = sync1_q;
    st_d     = st_q;
    cnt_d    = cnt_q + CntOne;
    xr_d     = xr_q;
    yr_d     = yr_q;
    btn_l_d  = btn_l_q;
    btn_r_d  = btn_r_q;
    pkt_d    = pkt_q;

    case (st_q)
      StIdle: begin
        if (!enable) begin
          cnt_d = '0;
        end else if (cnt_q == PollLast) begin
          st_d  = StXh;
          cnt_d = '0;
        end
      end
      StXh, StXl, StYh, StYl: begin
        if (!enable) begin
          // Abort: the partial read is dropped and the nibbles discarded.
          st_d  = StIdle;
          cnt_d = '0;
          xr_d  = '0;
          yr_d  = '0;
        end else if (at_settle) begin
          cnt_d = '0;
          case (st_q)
            StXh: begin
              xr_d[7:4] = nib;
              st_d      = StXl;
            end
            StXl: begin
              xr_d[3:0] = nib;
              st_d      = StYh;
            end
            StYh: begin
              yr_d[7:4] = nib;
              st_d      = StYl;
            end
            default: begin
              yr_d[3:0] = nib;
              btn_l_d   = ~sync2_q[4];
              btn_r_d   = ~sync2_q[5];
              st_d      = StPub;
            end
          endcase
        end
      end
      StPub: begin
        pkt_d = {~pkt_q[24], dy, dx, 2'b00, dy[7], dx[7], 2'b10, btn_r_q, btn_l_q};
        st_d  = StIdle;
        cnt_d = '0;
      end
      default: begin
        st_d  = StIdle;
        cnt_d = '0;
      end
    endcase

    strobe_d = (st_d == StXh) || (st_d == StYh);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st_q     <= StIdle;
      cnt_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      xr_q     <= '0;
      yr_q     <= '0;
      btn_l_q  <= 1'b0;
      btn_r_q  <= 1'b0;
      strobe_q <= 1'b0;
      pkt_q    <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      xr_q     <= xr_d;
      yr_q     <= yr_d;
      btn_l_q  <= btn_l_d;
      btn_r_q  <= btn_r_d;
      strobe_q <= strobe_d;
      pkt_q    <= pkt_d;
    end
  end

  assign strobe    = strobe_q;
  assign ps2_mouse = pkt_q;
  assign busy      = (st_q != StIdle);

endmodule

// File: tb/tb_msx_mouse_host.sv
// Self-checking bench for msx_mouse_host with a behavioural MSX mouse on the port.
module tb_msx_mouse_host;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        enable;
  logic [5:0]  pin_in;
  logic        strobe;
  logic [24:0] ps2_mouse;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_sys = ~clk_sys;

  msx_mouse_host #(
    .SETTLE_CYC(8),
    .POLL_CYC  (64),
    .CNT_W     (16)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .enable   (enable),
    .pin_in   (pin_in),
    .strobe   (strobe),
    .ps2_mouse(ps2_mouse),
    .busy     (busy)
  );

  // Mouse model: nibble sequence X hi, X lo, Y hi, Y lo, advancing on each strobe
  // edge; a rising edge after a long quiet spell restarts the sequence.
  logic [7:0] m_x = 8'h00;
  logic [7:0] m_y = 8'h00;
  logic       m_bl = 1'b0;
  logic       m_br = 1'b0;
  logic       glitch = 1'b0;
  int         idx = 0;
  longint     last_t = 0;
  logic [3:0] nib;

  always @(strobe) begin
    if (strobe === 1'b1 && ($time - last_t) > 300) idx = 0;
    else idx = idx + 1;
    last_t = $time;
  end

  always_comb begin
    case (idx)
      0:       nib = m_x[7:4];
      1:       nib = m_x[3:0];
      2:       nib = m_y[7:4];
      default: nib = m_y[3:0];
    endcase
  end

  assign pin_in = {~m_br, ~m_bl, nib[3:1], nib[0] ^ glitch};

  logic exp_tog = 1'b0;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_xh(output int n);
    n = 0;
    while (strobe !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
  endtask

  // One full read from the current point; expected values come from the mouse's
  // signed deltas, with X negated and clamped to the 8-bit range.
  task automatic run_read(input int exp_wait, input logic [7:0] x, input logic [7:0] y,
                          input logic bl, input logic br, input int g_start);
    int   n;
    bit   bad;
    int   sx, sy, ndx;
    logic [7:0] dx;
    m_x = x; m_y = y; m_bl = bl; m_br = br;
    wait_xh(n);
    check("xh_wait", n, exp_wait);
    check("busy_xh", busy, 1);
    bad = 0;
    for (int i = 1; i < 32; i++) begin
      if (i == g_start) glitch = 1'b1;
      if (i == g_start + 3) glitch = 1'b0;
      tick();
      if (strobe !== (((i / 8) % 2) == 0)) bad = 1;
    end
    check("strobe_seq", bad, 0);
    tick();
    check("busy_pub", busy, 1);
    check("no_early_toggle", ps2_mouse[24], exp_tog);
    tick();
    exp_tog = ~exp_tog;
    sx  = (x >= 128) ? int'(x) - 256 : int'(x);
    sy  = (y >= 128) ? int'(y) - 256 : int'(y);
    ndx = -sx;
    if (ndx > 127) ndx = 127;
    dx = ndx[7:0];
    check("toggle", ps2_mouse[24], exp_tog);
    check("dy", ps2_mouse[23:16], y);
    check("dx", ps2_mouse[15:8], dx);
    check("signs", ps2_mouse[5:4], {sy < 0, ndx < 0});
    check("fixed_bits", {ps2_mouse[7:6], ps2_mouse[3:2]}, 4'b0010);
    check("buttons", ps2_mouse[1:0], {br, bl});
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int n;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    check("rst_strobe", strobe, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt", ps2_mouse, 25'h0);

    reset  = 1'b0;
    enable = 1'b1;
    run_read(64, 8'h05, 8'hFB, 1'b0, 1'b0, -10);
    run_read(64, 8'h80, 8'h7F, 1'b1, 1'b0, -10);
    run_read(64, 8'h00, 8'h00, 1'b0, 1'b0, -10);
    run_read(64, 8'h00, 8'h00, 1'b0, 1'b0, -10);
    for (int k = 0; k < 6; k++) begin
      run_read(64, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), -10);
    end

    // Glitch on pin 1 early in XH, clear well before the sample.
    run_read(64, 8'h3C, 8'hA5, 1'b0, 1'b1, 1);

    // Abort during YH.
    wait_xh(n);
    check("abort_xh_wait", n, 64);
    repeat (16) tick();
    check("abort_in_yh", strobe, 1);
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check("abort_strobe", strobe, 0);
    check("abort_busy", busy, 0);
    repeat (5) tick();
    check("abort_no_toggle", ps2_mouse[24], exp_tog);
    enable = 1'b1;
    run_read(64, 8'hF0, 8'h01, 1'b1, 1'b1, -10);

    // Reset during XL after a packet already exists.
    wait_xh(n);
    check("rst_xh_wait", n, 64);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midrst_strobe", strobe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pkt", ps2_mouse, 25'h0);
    exp_tog = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    run_read(64, 8'h12, 8'h34, 1'b0, 1'b0, -10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/msx_mouse_host.md
# msx_mouse_host

Host-side reader for the MSX joystick-port mouse protocol. It drives pin 8 (strobe), collects the four delta nibbles and the two button lines, and republishes each read as a packet in the 25-bit `ps2_mouse` format. This is the initiator for the same protocol that the `ps2mouse` responder implements. It lets a real MSX mouse on the user port feed the existing `ps2_mouse` consumers, and gives the responder a loopback partner in simulation.

## Interface
- `SETTLE_CYC`, default 1024: `clk_sys` cycles from a strobe edge to the nibble sample. Must be ≥ 4 to cover the synchronizer.
- `POLL_CYC`, default 43000: idle `clk_sys` cycles between reads, about 2 ms at 21.48 MHz. Must exceed the mouse's 1.5 ms sequence-reset time.
- `CNT_W`, default 16: width of the shared cycle counter. Must hold `max(SETTLE_CYC, POLL_CYC)`.

Ports:
- `clk_sys`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high; clock is `clk_sys`.
- `enable`, input, 1: when high, polling runs; when low, the block idles with strobe low.
- `pin_in`, input, 6: raw port pins, asynchronous. Bits [3:0] are data pins 4..1 (bit 0 = pin 1), bit 4 = pin 6 (button L), bit 5 = pin 7 (button R). Pins are sampled without inversion.
- `strobe`, output, 1: drives pin 8.
- `ps2_mouse`, output, 25: packet bus.
  - [24] toggles once per new packet.
  - [23:16] = dy; [15:8] = dx.
  - [7:6] = 0; [5] = dy sign; [4] = dx sign; [3] = 1; [2] = 0.
  - [1] = right button; [0] = left button.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
- `pin_in` passes through a 2-flop synchronizer. All samples use the synchronized value.
- States are IDLE, XH, XL, YH, YL, PUB.
- IDLE:
  - `strobe` = 0 and the counter counts up.
  - When `enable` is high and the counter reaches POLL_CYC−1, go to XH and clear the counter.
  - While `enable` is low, the counter is held at 0.
- XH: `strobe` = 1. At count SETTLE_CYC−1, capture `xr[7:4]` ← data nibble, clear the counter, go to XL.
- XL: `strobe` = 0. At count SETTLE_CYC−1, capture `xr[3:0]`, go to YH.
- YH: `strobe` = 1. At count SETTLE_CYC−1, capture `yr[7:4]`, go to YL.
- YL: `strobe` = 0. At count SETTLE_CYC−1, capture `yr[3:0]`, capture `btnL = ~pin6` and `btnR = ~pin7`, go to PUB.
- PUB, one cycle:
  - Register all packet fields and invert bit 24.
  - Return to IDLE with the counter cleared.
- Arithmetic:
  - `xr` and `yr` are 8-bit two's complement, where MSX positive X means leftward and positive Y means upward.
  - dx = −xr. The special case xr = 0x80 saturates to dx = 0x7F.
  - dy = yr.
  - Each sign bit equals the MSB of its corresponding result.
- `enable` falling in XH..YL aborts the read:
  - Go to IDLE next cycle with `strobe` = 0.
  - No packet is published and the captured nibbles are discarded.
  - `enable` falling during PUB does not abort; PUB completes.
- `ps2_mouse` holds the last packet until the next PUB.

## Timing
- Reset values:
  - `strobe` = 0, `busy` = 0, `ps2_mouse` = 25'h0000000.
  - State is IDLE, counter = 0, synchronizer flops = 0.
- `reset` mid-read returns to IDLE on the next edge. No packet is published and bit 24 is unchanged from its reset value (0).
- First read: XH is entered POLL_CYC cycles after `reset` deasserts, provided `enable` was high throughout.
- `strobe` edges are registered and occur on the cycle of state entry.
- A nibble sample lands SETTLE_CYC cycles after its strobe edge. The effective pin-to-capture delay is ≥ SETTLE_CYC−2 cycles.
- Read length: XH entry to PUB is 4·SETTLE_CYC cycles. The bit-24 toggle is visible 4·SETTLE_CYC+1 cycles after XH entry.
- Packet period with `enable` held high: POLL_CYC + 4·SETTLE_CYC + 1 cycles.
- `busy` is high from XH entry through PUB inclusive.

## Test plan
Bench uses SETTLE_CYC = 8 and POLL_CYC = 64, with a behavioral mouse model that advances its nibble on each strobe edge.

1. Model sends X = 0x05, Y = 0xFB, buttons released → one toggle of [24], dx = 0xFB, dy = 0xFB, [5:4] = 2'b11, [3] = 1, [1:0] = 0. Strobe sequence is 1, 0, 1, 0, each level held 8 cycles.
2. Model sends X = 0x80, Y = 0x7F with pin 6 low → dx = 0x7F, dy = 0x7F, sign bits 0, [0] = 1, [1] = 0.
3. Continuous polling with zero deltas → a toggle every 64+32+1 = 97 cycles; the first XH entry is 64 cycles after reset release.
4. Drop `enable` during YH → `strobe` = 0 the next cycle, `busy` falls, no toggle. Re-raise `enable` → the next read starts 64 cycles later.
5. Assert `reset` during XL after a prior packet → all outputs return to reset values, including `ps2_mouse` = 0, with no spurious toggle.
6. Pin glitch on `pin_in[0]` shorter than the settle window, ending before sample cycle −2 → the captured nibble equals the model's value.
